// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and the helpers shared by the raster
// generator and its trigger conditioner.
package vga_timing_pkg;

  localparam int   DEF_H_ACTIVE        = 640;
  localparam int   DEF_H_FP            = 16;
  localparam int   DEF_H_SYNC          = 96;
  localparam int   DEF_H_BP            = 48;
  localparam int   DEF_V_ACTIVE        = 480;
  localparam int   DEF_V_FP            = 10;
  localparam int   DEF_V_SYNC          = 2;
  localparam int   DEF_V_BP            = 33;
  localparam logic DEF_SYNC_ACTIVE     = 1'b0;
  localparam int   DEF_DEBOUNCE_CYCLES = 125000;

  localparam int H_TOTAL        = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL        = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int H_SYNC_START   = DEF_H_ACTIVE + DEF_H_FP;
  localparam int H_SYNC_END     = H_SYNC_START + DEF_H_SYNC - 1;
  localparam int V_SYNC_START   = DEF_V_ACTIVE + DEF_V_FP;
  localparam int V_SYNC_END     = V_SYNC_START + DEF_V_SYNC - 1;
  localparam int FRAME_TICK_ROW = DEF_V_ACTIVE;

  // Inclusive range test used for the sync pulse windows.
  function automatic logic in_span(input logic [9:0] p, input logic [9:0] lo,
                                   input logic [9:0] hi);
    return (p >= lo) && (p <= hi);
  endfunction

endpackage

// File: rtl/trigger_debounce.sv
// Two-flop synchroniser followed by a run-length debouncer: the output level
// only follows the input after DEBOUNCE_CYCLES consecutive differing samples.
module trigger_debounce
  import vga_timing_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             meta;
  logic             s;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta  <= 1'b0;
      s     <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      meta <= raw;
      s    <= meta;
      // Any sample matching the accepted level discards the whole run.
      if (s == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a once-per-frame tick and a frame-aligned,
// debounced light-gun trigger.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE        = DEF_H_ACTIVE,
  parameter int   H_FP            = DEF_H_FP,
  parameter int   H_SYNC          = DEF_H_SYNC,
  parameter int   H_BP            = DEF_H_BP,
  parameter int   V_ACTIVE        = DEF_V_ACTIVE,
  parameter int   V_FP            = DEF_V_FP,
  parameter int   V_SYNC          = DEF_V_SYNC,
  parameter int   V_BP            = DEF_V_BP,
  parameter logic SYNC_ACTIVE     = DEF_SYNC_ACTIVE,
  parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger_raw,
  output logic       hsync,
  output logic       vsync,
  output logic       valid,
  output logic [9:0] col,
  output logic [9:0] row,
  output logic       frame_tick,
  output logic       trigger
);

  localparam logic [9:0] LINE_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] FRAME_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] TICK_ROW   = 10'(V_ACTIVE);

  logic [9:0] h;
  logic [9:0] v;
  logic       deb;
  logic       tick_next;

  trigger_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .reset(reset),
    .raw  (trigger_raw),
    .level(deb)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (h == LINE_LAST) begin
      h <= '0;
      v <= (v == FRAME_LAST) ? 10'd0 : v + 10'd1;
    end else begin
      h <= h + 10'd1;
    end
  end

  assign tick_next = (h == 10'd0) && (v == TICK_ROW);

  // Outputs are decoded from (h,v) one clock behind the counters, so the
  // first edge after reset presents (0,0) with every output aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col        <= '0;
      row        <= '0;
      valid      <= 1'b0;
      hsync      <= ~SYNC_ACTIVE;
      vsync      <= ~SYNC_ACTIVE;
      frame_tick <= 1'b0;
      trigger    <= 1'b0;
    end else begin
      col        <= h;
      row        <= v;
      valid      <= (h < H_VIS) && (v < V_VIS);
      hsync      <= in_span(h, HS_FIRST, HS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync      <= in_span(v, VS_FIRST, VS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      frame_tick <= tick_next;
      if (tick_next) trigger <= deb;
    end
  end

endmodule
